// File: rtl/instr_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, field positions, depth, FSM states.
// The STEP_WAIT state exists only when SINGLE_STEP_EN is defined.
package instr_pkg;

  localparam int DEPTH_DEFAULT = 10;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_BLT = 4'b1101;
  localparam logic [3:0] OP_BGT = 4'b1110;

  localparam int OP_HI   = 17;
  localparam int OP_LO   = 14;
  localparam int RID1_HI = 13;
  localparam int RID1_LO = 11;
  localparam int RID2_HI = 10;
  localparam int RID2_LO = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
`ifdef SINGLE_STEP_EN
    ST_STEP_WAIT = 2'd3,
`endif
    ST_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer for a raw active-low button plus a registered falling-edge pulse.
// Resets to the released level so no spurious press appears after reset.
module button_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic press_r;

  // Synchronize, remember previous level, and register the falling-edge pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      press_r <= prev_r & ~sync2_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/instr_sequencer.sv
// Stores a short program and issues it in order to the ALU over valid/ready on an execute press.
// Optional build macro: SINGLE_STEP_EN (one instruction per press).
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IW    = 18,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_data,
  input  logic          clear_prog,
  input  logic          execute_n,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_data,
  output logic [CW-1:0] instr_index,
  output logic [CW-1:0] instr_count,
  output logic          full,
  output logic          busy,
  output logic          done
);

  logic [IW-1:0] mem_r [0:DEPTH-1];

  seq_state_e    state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic [CW-1:0] pc_r, pc_s;
  logic          valid_r, valid_s;
  logic [IW-1:0] data_r, data_s;
  logic [CW-1:0] index_r, index_s;
  logic          done_r, done_s;
  logic          full_r, busy_r;
  logic          mem_we_s;
  logic          press_s;

  button_edge_sync u_exec_btn (
    .clock (clock),
    .reset (reset),
    .btn_n (execute_n),
    .press (press_s)
  );

  // Program storage; intentionally not reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[count_r] <= wr_data;
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    pc_s     = pc_r;
    valid_s  = valid_r;
    data_s   = data_r;
    index_s  = index_r;
    done_s   = 1'b0;
    mem_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_prog) begin
          count_s = {CW{1'b0}};
        end else if (press_s && (count_r != {CW{1'b0}})) begin
          pc_s    = {CW{1'b0}};
          state_s = ST_ISSUE;
          valid_s = 1'b1;
          data_s  = mem_r[0];
          index_s = {CW{1'b0}};
        end else if (press_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else if (wr_en && (count_r < CW'(DEPTH))) begin
          mem_we_s = 1'b1;
          count_s  = count_r + CW'(1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (valid_r && instr_ready) begin
          if (pc_r == (count_r - CW'(1))) begin
            valid_s = 1'b0;
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            pc_s = pc_r + CW'(1);
`ifdef SINGLE_STEP_EN
            valid_s = 1'b0;
            state_s = ST_STEP_WAIT;
`else
            data_s  = mem_r[pc_r + CW'(1)];
            index_s = pc_r + CW'(1);
`endif
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
`ifdef SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (press_s) begin
          state_s = ST_ISSUE;
          valid_s = 1'b1;
          data_s  = mem_r[pc_r];
          index_s = pc_r;
        end else begin
          state_s = ST_STEP_WAIT;
        end
      end
`endif
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CW{1'b0}};
      pc_r    <= {CW{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {IW{1'b0}};
      index_r <= {CW{1'b0}};
      done_r  <= 1'b0;
      full_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      pc_r    <= pc_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      index_r <= index_s;
      done_r  <= done_s;
      full_r  <= (count_s == CW'(DEPTH));
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign instr_valid = valid_r;
  assign instr_data  = data_r;
  assign instr_index = index_r;
  assign instr_count = count_r;
  assign full        = full_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
